// File: rtl/sdram_phase_autocal.sv
// -----------------------------------------------------------------------------
// sdram_phase_autocal
//
// Automatic SDRAM chip-clock phase calibration. Sweeps the dynamic phase of one
// ecp5pll output through a full period, scores every phase step with the
// memory tester's pass/fail counters, finds the longest circular run of clean
// steps and finally parks the phase in the centre of that run.
//
// Optional feature (compile-time macro SDRAM_PHASE_AUTOCAL_TRIM_EN):
//   adds trim_inc / trim_dec inputs for single-step manual trimming once the
//   calibration has finished. Without the macro those ports do not exist.
//
// Ports
//   clk           in   SDRAM system clock (same clock as mem_tester)
//   reset         in   asynchronous, active-high reset
//   start         in   single-cycle pulse, starts a new sweep (ignored while busy)
//   passcount     in   [31:0] mem_tester cumulative pass counter
//   failcount     in   [31:0] mem_tester cumulative fail counter
//   trim_inc      in   (macro only) advance the parked phase by one step
//   trim_dec      in   (macro only) retard the parked phase by one step
//   phasesel      out  [1:0] constant PLL output index C_phasesel
//   phasedir      out  0 = advance, 1 = retard
//   phasestep     out  step strobe, high C_pulse_cycles cycles per step
//   phaseloadreg  out  constant 0
//   phase         out  [7:0] position relative to reset, 0..C_steps-1
//   best_start    out  [7:0] first sweep index of the longest clean run
//   best_len      out  [8:0] length of that run
//   busy          out  sweep or seek in progress
//   done          out  calibration finished, phase parked
//   err           out  no clean step was found
// -----------------------------------------------------------------------------
module sdram_phase_autocal #(
    parameter int C_steps         = 16,
    parameter int C_phasesel      = 1,
    parameter int C_pulse_cycles  = 4,
    parameter int C_settle_cycles = 1024,
    parameter int C_dwell_passes  = 2,
    parameter int C_timeout       = 2**24,
    parameter int C_autostart     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] passcount,
    input  logic [31:0] failcount,
`ifdef SDRAM_PHASE_AUTOCAL_TRIM_EN
    input  logic        trim_inc,
    input  logic        trim_dec,
`endif
    output logic [1:0]  phasesel,
    output logic        phasedir,
    output logic        phasestep,
    output logic        phaseloadreg,
    output logic [7:0]  phase,
    output logic [7:0]  best_start,
    output logic [8:0]  best_len,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [8:0]  STEPS       = 9'(C_steps);
    localparam logic [8:0]  LAST        = 9'(C_steps - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(C_settle_cycles - 1);
    localparam logic [31:0] PULSE_LAST  = 32'(C_pulse_cycles - 1);
    localparam logic [31:0] TMO_LAST    = 32'(C_timeout - 1);
    localparam logic [31:0] DWELL_N     = 32'(C_dwell_passes);

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_SYNC, S_SNAP, S_DWELL, S_EVAL, S_STEP, S_SEEK, S_DONE
    } state_t;

    // What the STEP sequence returns to once the pulse is finished.
    typedef enum logic [1:0] {M_SWEEP, M_SEEK, M_TRIM} mode_t;
    typedef enum logic [1:0] {P_PRE, P_HIGH, P_LOW} sub_t;

    state_t      state_reg;
    mode_t       mode_reg;
    sub_t        sub_reg;
    logic        autostart_reg;
    logic [31:0] cnt_reg;
    logic [31:0] tmo_reg;
    logic        tmo_fail_reg;
    logic [31:0] pref_reg;
    logic [31:0] p0_reg;
    logic [31:0] f0_reg;
    logic [8:0]  idx_reg;
    logic        cur_open_reg;
    logic [8:0]  cur_start_reg;
    logic [8:0]  cur_len_reg;
    logic        lead_open_reg;
    logic [8:0]  lead_len_reg;
    logic [8:0]  seek_left_reg;
    logic        phasedir_reg;
    logic        phasestep_reg;
    logic [7:0]  phase_reg;
    logic [7:0]  best_start_reg;
    logic [8:0]  best_len_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;

    logic        step_clean;
    logic [8:0]  run_len_n;
    logic [8:0]  run_start_n;
    logic        merge_wrap;
    logic [8:0]  cand_len;
    logic [8:0]  centre_sum;
    logic [8:0]  centre_n;
    logic [7:0]  pos_next;
    logic        start_sweep;
    logic        trim_go;
    logic        trim_dir;

    assign phasesel     = 2'(C_phasesel);
    assign phaseloadreg = 1'b0;
    assign phasedir     = phasedir_reg;
    assign phasestep    = phasestep_reg;
    assign phase        = phase_reg;
    assign best_start   = best_start_reg;
    assign best_len     = best_len_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;

`ifdef SDRAM_PHASE_AUTOCAL_TRIM_EN
    // Both pulses together cancel out; start has priority over a trim.
    assign trim_go  = (state_reg == S_DONE) && !start && (trim_inc ^ trim_dec);
    assign trim_dir = trim_dec;
`else
    assign trim_go  = 1'b0;
    assign trim_dir = 1'b0;
`endif

    assign start_sweep = ((state_reg == S_IDLE) &&
                          (start || (autostart_reg && (C_autostart != 0)))) ||
                         ((state_reg == S_DONE) && start);

    always_comb begin
        // Modulo-2^32 delta: a wrapping tester counter is harmless.
        step_clean  = !tmo_fail_reg && ((failcount - f0_reg) == 32'd0);
        run_len_n   = cur_open_reg ? (cur_len_reg + 9'd1) : 9'd1;
        run_start_n = cur_open_reg ? cur_start_reg : idx_reg;
        // A run still open at the last index continues into the run that
        // started at index 0 (unless it is that very run).
        merge_wrap  = (idx_reg == LAST) && (run_start_n != 9'd0) && (lead_len_reg != 9'd0);
        cand_len    = merge_wrap ? (run_len_n + lead_len_reg) : run_len_n;

        centre_sum  = {1'b0, best_start_reg} + {1'b0, best_len_reg[8:1]};
        if (best_len_reg == STEPS) begin
            centre_n = 9'd0;
        end else if (centre_sum >= STEPS) begin
            centre_n = centre_sum - STEPS;
        end else begin
            centre_n = centre_sum;
        end

        if (!phasedir_reg) begin
            pos_next = ({1'b0, phase_reg} == LAST) ? 8'd0 : (phase_reg + 8'd1);
        end else begin
            pos_next = (phase_reg == 8'd0) ? LAST[7:0] : (phase_reg - 8'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            mode_reg       <= M_SWEEP;
            sub_reg        <= P_PRE;
            autostart_reg  <= 1'b1;
            cnt_reg        <= '0;
            tmo_reg        <= '0;
            tmo_fail_reg   <= 1'b0;
            pref_reg       <= '0;
            p0_reg         <= '0;
            f0_reg         <= '0;
            idx_reg        <= '0;
            cur_open_reg   <= 1'b0;
            cur_start_reg  <= '0;
            cur_len_reg    <= '0;
            lead_open_reg  <= 1'b0;
            lead_len_reg   <= '0;
            seek_left_reg  <= '0;
            phasedir_reg   <= 1'b0;
            phasestep_reg  <= 1'b0;
            phase_reg      <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            autostart_reg <= 1'b0;
            if (start_sweep) begin
                // The current position becomes sweep index 0.
                state_reg      <= S_SETTLE;
                busy_reg       <= 1'b1;
                done_reg       <= 1'b0;
                err_reg        <= 1'b0;
                idx_reg        <= '0;
                cur_open_reg   <= 1'b0;
                cur_start_reg  <= '0;
                cur_len_reg    <= '0;
                lead_open_reg  <= 1'b0;
                lead_len_reg   <= '0;
                best_start_reg <= '0;
                best_len_reg   <= '0;
                cnt_reg        <= '0;
                tmo_reg        <= '0;
                tmo_fail_reg   <= 1'b0;
            end else if (trim_go) begin
                mode_reg     <= M_TRIM;
                phasedir_reg <= trim_dir;
                sub_reg      <= P_PRE;
                cnt_reg      <= '0;
                done_reg     <= 1'b0;
                state_reg    <= S_STEP;
            end else begin
                case (state_reg)
                    S_SETTLE: begin
                        pref_reg <= passcount;
                        if (cnt_reg >= SETTLE_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= S_SYNC;
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end
                    S_SYNC: begin
                        // The pass in flight during the step is discarded.
                        tmo_reg <= tmo_reg + 32'd1;
                        if (passcount != pref_reg) begin
                            state_reg <= S_SNAP;
                        end else if (tmo_reg >= TMO_LAST) begin
                            tmo_fail_reg <= 1'b1;
                            state_reg    <= S_EVAL;
                        end
                    end
                    S_SNAP: begin
                        tmo_reg   <= tmo_reg + 32'd1;
                        p0_reg    <= passcount;
                        f0_reg    <= failcount;
                        state_reg <= S_DWELL;
                    end
                    S_DWELL: begin
                        tmo_reg <= tmo_reg + 32'd1;
                        if ((passcount - p0_reg) >= DWELL_N) begin
                            state_reg <= S_EVAL;
                        end else if (tmo_reg >= TMO_LAST) begin
                            tmo_fail_reg <= 1'b1;
                            state_reg    <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        if (step_clean) begin
                            cur_open_reg  <= 1'b1;
                            cur_len_reg   <= run_len_n;
                            cur_start_reg <= run_start_n;
                            if ((idx_reg == 9'd0) || lead_open_reg) begin
                                lead_open_reg <= 1'b1;
                                lead_len_reg  <= lead_len_reg + 9'd1;
                            end
                            // Strictly longer only: ties keep the earlier run.
                            if (cand_len > best_len_reg) begin
                                best_start_reg <= run_start_n[7:0];
                                best_len_reg   <= cand_len;
                            end
                        end else begin
                            cur_open_reg  <= 1'b0;
                            cur_len_reg   <= '0;
                            lead_open_reg <= 1'b0;
                        end
                        mode_reg     <= M_SWEEP;
                        phasedir_reg <= 1'b0;
                        sub_reg      <= P_PRE;
                        cnt_reg      <= '0;
                        state_reg    <= S_STEP;
                    end
                    S_STEP: begin
                        // PRE gives phasedir one settled cycle before the strobe.
                        case (sub_reg)
                            P_PRE: begin
                                phasestep_reg <= 1'b1;
                                cnt_reg       <= '0;
                                sub_reg       <= P_HIGH;
                            end
                            P_HIGH: begin
                                if (cnt_reg >= PULSE_LAST) begin
                                    phasestep_reg <= 1'b0;
                                    phase_reg     <= pos_next;
                                    sub_reg       <= P_LOW;
                                end else begin
                                    cnt_reg <= cnt_reg + 32'd1;
                                end
                            end
                            default: begin
                                sub_reg <= P_PRE;
                                case (mode_reg)
                                    M_SWEEP: begin
                                        if (idx_reg == LAST) begin
                                            // Back at index 0: seek the centre from here.
                                            seek_left_reg <= centre_n;
                                            state_reg     <= S_SEEK;
                                        end else begin
                                            idx_reg      <= idx_reg + 9'd1;
                                            cnt_reg      <= '0;
                                            tmo_reg      <= '0;
                                            tmo_fail_reg <= 1'b0;
                                            state_reg    <= S_SETTLE;
                                        end
                                    end
                                    M_SEEK: state_reg <= S_SEEK;
                                    default: begin
                                        done_reg  <= 1'b1;
                                        state_reg <= S_DONE;
                                    end
                                endcase
                            end
                        endcase
                    end
                    S_SEEK: begin
                        if (best_len_reg == 9'd0) begin
                            err_reg   <= 1'b1;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (seek_left_reg == 9'd0) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            seek_left_reg <= seek_left_reg - 9'd1;
                            mode_reg      <= M_SEEK;
                            phasedir_reg  <= 1'b0;
                            sub_reg       <= P_PRE;
                            cnt_reg       <= '0;
                            state_reg     <= S_STEP;
                        end
                    end
                    S_IDLE, S_DONE: begin
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule
